// File: rtl/synch_fifo_reader_pkg.sv
// rtl/synch_fifo_reader_pkg.sv - shared constants for synch_fifo and its read-side controller
package synch_fifo_reader_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int RD_BUF_DEPTH   = 2;
    localparam int BUF_CNT_W      = 2;

endpackage

// File: rtl/synch_fifo_reader.sv
// rtl/synch_fifo_reader.sv - absorbs synch_fifo read latency and re-presents words as a valid/ready stream
module synch_fifo_reader
    import synch_fifo_reader_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] read_data,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [BUF_CNT_W-1:0]  buf_cnt
);

    localparam logic [BUF_CNT_W:0] DEPTH = RD_BUF_DEPTH[BUF_CNT_W:0];

    logic [FIFO_WIDTH-1:0] slot0_q, slot0_d;
    logic [FIFO_WIDTH-1:0] slot1_q, slot1_d;
    logic [BUF_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic                  m_valid_q, m_valid_d;
    logic                  pop;
    logic [BUF_CNT_W:0]    occ_next;
    logic [BUF_CNT_W-1:0]  kept;

    assign pop      = m_valid_q && m_ready;
    // occupancy once this cycle's pop and any landing read are accounted for
    assign occ_next = {1'b0, cnt_q} + {{BUF_CNT_W{1'b0}}, pend_q} - {{BUF_CNT_W{1'b0}}, pop};
    assign kept     = cnt_q - {{(BUF_CNT_W-1){1'b0}}, pop};
    assign rd_en    = !rst && !fifo_empty && (occ_next < DEPTH);

    always_comb begin
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        pend_d    = rd_en;
        cnt_d     = occ_next[BUF_CNT_W-1:0];
        m_valid_d = (occ_next != '0);
        if (pop && cnt_q == 2'd2) begin
            slot0_d = slot1_q;
        end
        // landing word goes to the first slot still free after the pop
        if (pend_q) begin
            if (kept == '0) begin
                slot0_d = read_data;
            end else begin
                slot1_d = read_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q   <= '0;
            slot1_q   <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = slot0_q;
    assign buf_cnt = cnt_q;

endmodule
